// File: rtl/fw_rule_matcher_if.sv
`default_nettype none
// ============================================================================
// fw_rule_matcher_if
// Header-in, verdict-out and rule-programming bus of the rule matcher.
// Revision: 1.0
// ============================================================================
interface fw_rule_matcher_if #(
  parameter int TAG_W = 2,
  parameter int IDX_W = 3
);
  logic             hdr_valid;
  logic             hdr_ready;
  logic             hdr_id;
  logic [TAG_W-1:0] hdr_tag;
  logic [7:0]       hdr_protocol;
  logic [31:0]      hdr_srcip;
  logic [31:0]      hdr_dstip;
  logic [15:0]      hdr_srcport;
  logic [15:0]      hdr_dstport;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [TAG_W-1:0] res_tag;
  logic             res_result;

  logic             cfg_we;
  logic             cfg_ready;
  logic [IDX_W-1:0] cfg_idx;
  logic             cfg_en;
  logic             cfg_allow;
  logic [7:0]       cfg_protocol;
  logic [31:0]      cfg_srcip;
  logic [31:0]      cfg_srcmask;
  logic [31:0]      cfg_dstip;
  logic [31:0]      cfg_dstmask;
  logic [15:0]      cfg_dport_lo;
  logic [15:0]      cfg_dport_hi;

  modport slave (
    input  hdr_valid, hdr_id, hdr_tag, hdr_protocol, hdr_srcip, hdr_dstip,
           hdr_srcport, hdr_dstport,
    output hdr_ready,
    output res_valid, res_id, res_tag, res_result,
    input  res_ready,
    input  cfg_we, cfg_idx, cfg_en, cfg_allow, cfg_protocol, cfg_srcip,
           cfg_srcmask, cfg_dstip, cfg_dstmask, cfg_dport_lo, cfg_dport_hi,
    output cfg_ready
  );

  modport master (
    output hdr_valid, hdr_id, hdr_tag, hdr_protocol, hdr_srcip, hdr_dstip,
           hdr_srcport, hdr_dstport,
    input  hdr_ready,
    input  res_valid, res_id, res_tag, res_result,
    output res_ready,
    output cfg_we, cfg_idx, cfg_en, cfg_allow, cfg_protocol, cfg_srcip,
           cfg_srcmask, cfg_dstip, cfg_dstmask, cfg_dport_lo, cfg_dport_hi,
    input  cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/fw_rule_matcher.sv
`default_nettype none
// ============================================================================
// fw_rule_matcher
// First-match packet-filter rule scan, one rule per cycle, with saturating stats.
// Revision: 1.0
// ============================================================================
module fw_rule_matcher #(
  parameter int NUM_RULES     = 8,
  parameter int TAG_W         = 2,
  parameter bit DEFAULT_ALLOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  fw_rule_matcher_if.slave    bus,
  output logic [15:0]         stat_allow,
  output logic [15:0]         stat_drop
);
  localparam int IDX_W = $clog2(NUM_RULES);
  localparam int K_W   = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [K_W-1:0] k_q, k_d;

  logic             hdr_id_q, hdr_id_d;
  logic [TAG_W-1:0] hdr_tag_q, hdr_tag_d;
  logic [7:0]       hdr_protocol_q, hdr_protocol_d;
  logic [31:0]      hdr_srcip_q, hdr_srcip_d;
  logic [31:0]      hdr_dstip_q, hdr_dstip_d;
  logic [15:0]      hdr_dstport_q, hdr_dstport_d;

  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_result_q, res_result_d;

  logic [15:0] stat_allow_q, stat_allow_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  logic [NUM_RULES-1:0]       rule_en_q, rule_en_d;
  logic [NUM_RULES-1:0]       rule_allow_q, rule_allow_d;
  logic [NUM_RULES-1:0][7:0]  rule_proto_q, rule_proto_d;
  logic [NUM_RULES-1:0][31:0] rule_srcip_q, rule_srcip_d;
  logic [NUM_RULES-1:0][31:0] rule_srcmask_q, rule_srcmask_d;
  logic [NUM_RULES-1:0][31:0] rule_dstip_q, rule_dstip_d;
  logic [NUM_RULES-1:0][31:0] rule_dstmask_q, rule_dstmask_d;
  logic [NUM_RULES-1:0][15:0] rule_dlo_q, rule_dlo_d;
  logic [NUM_RULES-1:0][15:0] rule_dhi_q, rule_dhi_d;

  // Source port travels with the header but never takes part in matching.
  logic unused_srcport;
  assign unused_srcport = ^bus.hdr_srcport;

  logic [IDX_W-1:0] k_idx;
  logic             rule_hit;
  assign k_idx = k_q[IDX_W-1:0];
  assign rule_hit = rule_en_q[k_idx]
                 && (rule_proto_q[k_idx] == 8'd0 || rule_proto_q[k_idx] == hdr_protocol_q)
                 && (((hdr_srcip_q ^ rule_srcip_q[k_idx]) & rule_srcmask_q[k_idx]) == 32'd0)
                 && (((hdr_dstip_q ^ rule_dstip_q[k_idx]) & rule_dstmask_q[k_idx]) == 32'd0)
                 && (rule_dlo_q[k_idx] <= hdr_dstport_q)
                 && (hdr_dstport_q <= rule_dhi_q[k_idx]);

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    hdr_id_d       = hdr_id_q;
    hdr_tag_d      = hdr_tag_q;
    hdr_protocol_d = hdr_protocol_q;
    hdr_srcip_d    = hdr_srcip_q;
    hdr_dstip_d    = hdr_dstip_q;
    hdr_dstport_d  = hdr_dstport_q;
    res_valid_d    = res_valid_q;
    res_id_d       = res_id_q;
    res_tag_d      = res_tag_q;
    res_result_d   = res_result_q;
    stat_allow_d   = stat_allow_q;
    stat_drop_d    = stat_drop_q;
    rule_en_d      = rule_en_q;
    rule_allow_d   = rule_allow_q;
    rule_proto_d   = rule_proto_q;
    rule_srcip_d   = rule_srcip_q;
    rule_srcmask_d = rule_srcmask_q;
    rule_dstip_d   = rule_dstip_q;
    rule_dstmask_d = rule_dstmask_q;
    rule_dlo_d     = rule_dlo_q;
    rule_dhi_d     = rule_dhi_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_we) begin
          rule_en_d[bus.cfg_idx]      = bus.cfg_en;
          rule_allow_d[bus.cfg_idx]   = bus.cfg_allow;
          rule_proto_d[bus.cfg_idx]   = bus.cfg_protocol;
          rule_srcip_d[bus.cfg_idx]   = bus.cfg_srcip;
          rule_srcmask_d[bus.cfg_idx] = bus.cfg_srcmask;
          rule_dstip_d[bus.cfg_idx]   = bus.cfg_dstip;
          rule_dstmask_d[bus.cfg_idx] = bus.cfg_dstmask;
          rule_dlo_d[bus.cfg_idx]     = bus.cfg_dport_lo;
          rule_dhi_d[bus.cfg_idx]     = bus.cfg_dport_hi;
        end
        if (bus.hdr_valid) begin
          hdr_id_d       = bus.hdr_id;
          hdr_tag_d      = bus.hdr_tag;
          hdr_protocol_d = bus.hdr_protocol;
          hdr_srcip_d    = bus.hdr_srcip;
          hdr_dstip_d    = bus.hdr_dstip;
          hdr_dstport_d  = bus.hdr_dstport;
          k_d            = '0;
          state_d        = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // k reaching NUM_RULES means every slot missed: one extra cycle for the default.
        if (k_q[IDX_W] || rule_hit) begin
          res_result_d = k_q[IDX_W] ? DEFAULT_ALLOW : rule_allow_q[k_idx];
          res_valid_d  = 1'b1;
          res_id_d     = hdr_id_q;
          res_tag_d    = hdr_tag_q;
          state_d      = ST_RESP;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.res_ready) begin
          if (res_result_q) begin
            if (stat_allow_q != 16'hFFFF) stat_allow_d = stat_allow_q + 16'd1;
          end else begin
            if (stat_drop_q != 16'hFFFF) stat_drop_d = stat_drop_q + 16'd1;
          end
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      hdr_id_q       <= 1'b0;
      hdr_tag_q      <= '0;
      hdr_protocol_q <= '0;
      hdr_srcip_q    <= '0;
      hdr_dstip_q    <= '0;
      hdr_dstport_q  <= '0;
      res_valid_q    <= 1'b0;
      res_id_q       <= 1'b0;
      res_tag_q      <= '0;
      res_result_q   <= 1'b0;
      stat_allow_q   <= '0;
      stat_drop_q    <= '0;
      rule_en_q      <= '0;
      rule_allow_q   <= '0;
      rule_proto_q   <= '0;
      rule_srcip_q   <= '0;
      rule_srcmask_q <= '0;
      rule_dstip_q   <= '0;
      rule_dstmask_q <= '0;
      rule_dlo_q     <= '0;
      rule_dhi_q     <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      hdr_id_q       <= hdr_id_d;
      hdr_tag_q      <= hdr_tag_d;
      hdr_protocol_q <= hdr_protocol_d;
      hdr_srcip_q    <= hdr_srcip_d;
      hdr_dstip_q    <= hdr_dstip_d;
      hdr_dstport_q  <= hdr_dstport_d;
      res_valid_q    <= res_valid_d;
      res_id_q       <= res_id_d;
      res_tag_q      <= res_tag_d;
      res_result_q   <= res_result_d;
      stat_allow_q   <= stat_allow_d;
      stat_drop_q    <= stat_drop_d;
      rule_en_q      <= rule_en_d;
      rule_allow_q   <= rule_allow_d;
      rule_proto_q   <= rule_proto_d;
      rule_srcip_q   <= rule_srcip_d;
      rule_srcmask_q <= rule_srcmask_d;
      rule_dstip_q   <= rule_dstip_d;
      rule_dstmask_q <= rule_dstmask_d;
      rule_dlo_q     <= rule_dlo_d;
      rule_dhi_q     <= rule_dhi_d;
    end
  end

  assign bus.hdr_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.cfg_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.res_result = res_result_q;
  assign stat_allow     = stat_allow_q;
  assign stat_drop      = stat_drop_q;
endmodule
`default_nettype wire
